// File: rtl/mem_access_unit_if.sv
// Data-memory bus: valid/ready request channel plus a variable-latency read response.
interface mem_access_unit_if;
  logic        dmem_valid;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V memory stage: data-bus load/store sequencing, lane steering, load
// alignment/extension, misalignment detection and the MEM/WB register.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr_M,
  input  logic        mem_wr_M,
  input  logic        mem_rd_M,
  input  logic [2:0]  mem_mask_M,
  input  logic [1:0]  sel_wb_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  input  logic [4:0]  rd_M,
  input  logic [31:0] PC4_M,
  output logic        stall_M,
  mem_access_unit_if.master dmem,
  output logic        reg_wr_W,
  output logic [1:0]  sel_wb_W,
  output logic [31:0] alu_o_W,
  output logic [31:0] ld_data_W,
  output logic [4:0]  rd_W,
  output logic [31:0] PC4_W,
  output logic        fault_W
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  off_reg;
  logic [2:0]  mask_reg;

  logic        mem_op, fault, req_ok;
  logic        is_byte, is_half, is_word, illegal_width;
  logic [1:0]  off;
  logic [3:0]  be_vec;
  logic [31:0] wdata_vec;
  logic [31:0] shifted, ld_ext;

  assign off           = alu_o_M[1:0];
  assign mem_op        = mem_rd_M | mem_wr_M;
  assign is_byte       = (mem_mask_M[1:0] == 2'b00);
  assign is_half       = (mem_mask_M[1:0] == 2'b01);
  assign is_word       = (mem_mask_M == 3'b010);
  assign illegal_width = (mem_mask_M == 3'b011) | (mem_mask_M == 3'b110) | (mem_mask_M == 3'b111);
  assign fault         = mem_op & (illegal_width | (is_half & off[0]) | (is_word & (off != 2'b00)));
  assign req_ok        = mem_op & ~fault;

  // Each lane picks the store byte that lands on it; narrower stores are replicated.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be_vec[gi] = mem_wr_M & (is_word
                                      | (is_half & (off[1] == LANE[1]))
                                      | (is_byte & (off == LANE)));
      assign wdata_vec[8*gi +: 8] = !mem_wr_M ? 8'h00 :
                                    is_word   ? wr_data_M[8*gi +: 8] :
                                    is_half   ? wr_data_M[8*(gi%2) +: 8] :
                                                wr_data_M[7:0];
    end
  endgenerate

  assign dmem.dmem_we    = mem_wr_M;
  assign dmem.dmem_addr  = {alu_o_M[31:2], 2'b00};
  assign dmem.dmem_be    = be_vec;
  assign dmem.dmem_wdata = wdata_vec;

  always_comb begin
    state_next      = state_reg;
    dmem.dmem_valid = 1'b0;
    stall_M         = 1'b0;
    if (rst) begin
      case (state_reg)
        IDLE: begin
          if (req_ok) begin
            dmem.dmem_valid = 1'b1;
            if (!dmem.dmem_ready) begin
              stall_M    = 1'b1;
              state_next = REQ;
            end else if (mem_rd_M) begin
              stall_M    = 1'b1;
              state_next = WAIT_RSP;
            end
          end
        end
        REQ: begin
          dmem.dmem_valid = 1'b1;
          if (!dmem.dmem_ready) begin
            stall_M = 1'b1;
          end else if (mem_rd_M) begin
            stall_M    = 1'b1;
            state_next = WAIT_RSP;
          end else begin
            state_next = IDLE;
          end
        end
        WAIT_RSP: begin
          if (dmem.dmem_rvalid) state_next = IDLE;
          else                  stall_M    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Offset and width are captured at acceptance so extraction does not rely on upstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      off_reg   <= 2'b00;
      mask_reg  <= 3'b000;
    end else begin
      state_reg <= state_next;
      if (dmem.dmem_valid && dmem.dmem_ready) begin
        off_reg  <= off;
        mask_reg <= mem_mask_M;
      end
    end
  end

  always_comb begin
    shifted = dmem.dmem_rdata >> {off_reg, 3'b000};
    case (mask_reg)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'h000000, shifted[7:0]};
      3'b101:  ld_ext = {16'h0000, shifted[15:0]};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  // A stalled cycle retires a bubble so each instruction reaches WB exactly once.
  always_ff @(posedge clk) begin
    if (!rst || stall_M) begin
      reg_wr_W  <= 1'b0;
      sel_wb_W  <= 2'b00;
      alu_o_W   <= 32'h0;
      ld_data_W <= 32'h0;
      rd_W      <= 5'd0;
      PC4_W     <= 32'h0;
      fault_W   <= 1'b0;
    end else begin
      reg_wr_W  <= reg_wr_M & ~fault;
      sel_wb_W  <= sel_wb_M;
      alu_o_W   <= alu_o_M;
      ld_data_W <= (mem_rd_M && !fault) ? ld_ext : 32'h0;
      rd_W      <= rd_M;
      PC4_W     <= PC4_M;
      fault_W   <= fault;
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage datapath of the 5-stage RISC-V core, sitting directly downstream of the EX/MEM pipeline register. It takes the M-stage control and datapath signals, runs loads and stores on the data-memory bus with a valid/ready request and a variable-latency read response, and raises `stall_M` while an access is outstanding. It also steers store byte lanes, aligns and extends load data, detects misaligned accesses, and registers the results into the MEM/WB stage.

## Interface
- No parameters; XLEN fixed at 32.
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `reg_wr_M`, `mem_wr_M`, `mem_rd_M`  in  1 each  M-stage control; `mem_wr_M` and `mem_rd_M` are never both 1
- `mem_mask_M`  in  3  funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `sel_wb_M`  in  2  writeback select, passed through
- `alu_o_M`  in  32  effective address, or ALU result
- `wr_data_M`  in  32  store data
- `rd_M`  in  5  destination register
- `PC4_M`  in  32  PC+4
- `stall_M`  out  1  freeze upstream stages (combinational)
- `dmem_valid`  out  1  request valid
- `dmem_ready`  in  1  request accepted when valid and ready are both 1
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word address `{alu_o_M[31:2],2'b00}`
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_rvalid`  in  1  read response valid
- `dmem_rdata`  in  32  read response word
- `reg_wr_W`, `sel_wb_W`, `alu_o_W`, `ld_data_W`, `rd_W`, `PC4_W`  out  1/2/32/32/5/32  MEM/WB register outputs
- `fault_W`  out  1  misaligned or illegal-width access retired

## Operation
- `mem_op` = `mem_rd_M | mem_wr_M`.
- `fault` = `mem_op` and any of:
  - `mem_mask_M` in {011, 110, 111};
  - H/HU with `alu_o_M[0]` = 1;
  - W with `alu_o_M[1:0]` ≠ 0.
- A faulting access issues no bus request and causes no stall.
- Store lanes, with `off` = `alu_o_M[1:0]`:
  - SB: `be` = 4'b0001<<off, `wdata` = {4{`wr_data_M[7:0]`}}.
  - SH: `be` = 4'b0011<<off, `wdata` = {2{`wr_data_M[15:0]`}}.
  - SW: `be` = 1111, `wdata` = `wr_data_M`.
- For loads, `dmem_be` = 0000 and `dmem_wdata` = 0.
- Load extract: shift `dmem_rdata` right by 8·`off_q`, take the low byte or half, then sign-extend (B/H) or zero-extend (BU/HU). LW takes the word unchanged. `off_q` and `mask_q` are latched when the request is accepted.
- FSM states: IDLE, REQ, WAIT_RSP.
  - **IDLE.** With a non-faulting `mem_op`, drive `dmem_valid`=1.
    - Ready=1 and store: the store completes; `stall_M`=0; stay in IDLE.
    - Ready=1 and load: go to WAIT_RSP; `stall_M`=1.
    - Ready=0: go to REQ; `stall_M`=1.
  - **REQ.** Hold `dmem_valid`=1 with unchanged address, data and enables; upstream is frozen, so the inputs are stable.
    - Ready=1 and store: go to IDLE; `stall_M`=0.
    - Ready=1 and load: go to WAIT_RSP; `stall_M`=1.
  - **WAIT_RSP.** `dmem_valid`=0 and `stall_M`=1 until `dmem_rvalid`. On `dmem_rvalid`: `stall_M`=0, capture the extracted data, go to IDLE.
  - `dmem_rvalid` in IDLE or REQ is ignored. A response never arrives in the same cycle as acceptance.
- MEM/WB register loads whenever `stall_M`=0:
  - `reg_wr_W` = `reg_wr_M & ~fault`;
  - `sel_wb_W`, `alu_o_W`, `rd_W`, `PC4_W` pass through;
  - `ld_data_W` = extracted load data, or 0 for non-loads;
  - `fault_W` = `fault`.
- While `stall_M`=1 the register loads a bubble (all outputs 0), so no retirement is ever duplicated.

## Timing
- Reset (`rst`=0 at the edge): state goes to IDLE and all `_W` outputs go to 0. While `rst`=0, `dmem_valid`=0 and `stall_M`=0. An outstanding request or response is abandoned, and a late `dmem_rvalid` after reset is ignored in IDLE.
- Non-memory ops, faulting ops, and stores accepted in their first cycle appear on the `_W` outputs one cycle after entering M, with no stall.
- Load latency: M-entry to `_W` = (cycles until ready) + (cycles from acceptance until rvalid) + 1 register edge.
- `stall_M` depends combinationally on `dmem_ready` (IDLE/REQ) and `dmem_rvalid` (WAIT_RSP). It has no path from `_W` outputs.
- `dmem_valid` never drops in REQ before acceptance, and no second request is issued while in WAIT_RSP.

## Test plan
- **Zero-wait store.** SB with `alu_o_M`=0x1003, `wr_data_M`=0xAB, ready=1 → same cycle: `dmem_be`=1000, `dmem_wdata`=0xABABABAB, `dmem_addr`=0x1000, `stall_M`=0; next cycle `reg_wr_W`=0.
- **Wait-stated load.** LH with `alu_o_M`=0x2002, ready low for 2 cycles, rvalid 3 cycles after acceptance with `rdata`=0x8001_1234 → `stall_M` high for 5 cycles; `ld_data_W`=0xFFFF8001, `rd_W` matches; the `_W` outputs were bubbles during the stall.
- **LBU / LW.** LBU at offset 1 with `rdata`=0x0000F500 → `ld_data_W`=0x000000F5. LW with `rdata`=0xDEADBEEF → 0xDEADBEEF.
- **Misaligned access.** LW with `alu_o_M`=0x3002 → `dmem_valid`=0, `stall_M`=0, next cycle `fault_W`=1, `reg_wr_W`=0. Same result for SH at 0x3001.
- **Reset mid-load.** Assert `rst`=0 while in WAIT_RSP, then pulse `dmem_rvalid` after release → `_W` outputs all 0, state IDLE, the response is ignored and `stall_M`=0.
- **Back-to-back ALU ops.** ALU ops at 0x10 and 0x20 with `reg_wr_M`=1 → `alu_o_W`=0x10 then 0x20 on consecutive cycles; `stall_M` never asserted.
